// File: rtl/tx_record_packer.sv
// Packs narrow user words into fixed-size records, MSB slot first, and buffers up to
// three closed records ahead of a tx_streamer-style valid/dreq output.
module tx_record_packer #(
  parameter int unsigned g_word_width    = 16,
  parameter int unsigned g_record_size   = 64,
  parameter int unsigned g_flush_timeout = 512
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_i,
  input  logic [g_word_width-1:0]  in_data_i,
  input  logic                     in_valid_i,
  input  logic                     in_last_i,
  output logic                     in_dreq_o,
  output logic [g_record_size-1:0] tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_dreq_i,
  output logic                     tx_partial_o,
  output logic                     overflow_o
);

  localparam int unsigned Slots = g_record_size / g_word_width;
  localparam int unsigned WcW   = $clog2(Slots);
  localparam int unsigned IdleW = (g_flush_timeout > 0) ? $clog2(g_flush_timeout + 1) : 1;
  localparam int unsigned Depth = 3;

  logic [g_record_size-1:0] rec_q, rec_d;
  logic [WcW-1:0]           wc_q, wc_d, wc_eff, wc_inc;
  logic [IdleW-1:0]         idle_q, idle_d;
  logic [g_record_size:0]   mem_q [Depth];
  logic [1:0]               wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic [g_record_size-1:0] tx_data_q;
  logic                     tx_valid_q, tx_partial_q, overflow_q, in_dreq_q;

  logic                     pop, can_push, timeout_hit, word_close;
  logic                     push, push_partial, drop;
  logic [g_record_size-1:0] push_data, word_top, placed, word_rec;

  assign pop         = tx_dreq_i && (count_q != 2'd0);
  // A pop at the same edge frees the head slot, so a push into a full FIFO still fits.
  assign can_push    = (count_q < 2'(Depth)) || pop;
  assign timeout_hit = (g_flush_timeout > 0) && (wc_q != '0) &&
                       (idle_q == IdleW'(g_flush_timeout));

  // A pending timeout close means the incoming word starts a fresh record.
  assign wc_eff   = timeout_hit ? '0 : wc_q;
  assign wc_inc   = wc_eff + 1'b1;
  assign word_top = {in_data_i, {(g_record_size - g_word_width){1'b0}}};
  assign placed   = word_top >> (32'(wc_eff) * g_word_width);
  assign word_rec = ((wc_eff == '0) ? '0 : rec_q) | placed;
  assign word_close = in_last_i || (wc_eff == WcW'(Slots - 1));

  always_comb begin
    push         = 1'b0;
    push_data    = rec_q;
    push_partial = 1'b1;
    drop         = 1'b0;
    rec_d        = rec_q;
    wc_d         = wc_q;
    idle_d       = idle_q;
    if (in_valid_i) begin
      if (timeout_hit) begin
        if (can_push) push = 1'b1;
        else          drop = 1'b1;
      end
      idle_d = '0;
      if (word_close && timeout_hit) begin
        // Second close in one edge: park it as a pending timeout close.
        rec_d  = word_rec;
        wc_d   = wc_inc;
        idle_d = IdleW'(g_flush_timeout);
      end else if (word_close) begin
        wc_d = '0;
        if (can_push) begin
          push         = 1'b1;
          push_data    = word_rec;
          push_partial = (wc_eff != WcW'(Slots - 1));
        end else begin
          drop = 1'b1;
        end
      end else begin
        rec_d = word_rec;
        wc_d  = wc_inc;
      end
    end else if (timeout_hit) begin
      if (can_push) begin
        push   = 1'b1;
        wc_d   = '0;
        idle_d = '0;
      end
    end else if ((g_flush_timeout > 0) && (wc_q != '0)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign count_d = count_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rec_q        <= '0;
      wc_q         <= '0;
      idle_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_partial_q <= 1'b0;
      overflow_q   <= 1'b0;
      in_dreq_q    <= 1'b0;
    end else begin
      rec_q      <= rec_d;
      wc_q       <= wc_d;
      idle_q     <= idle_d;
      count_q    <= count_d;
      in_dreq_q  <= (count_d <= 2'd1);
      overflow_q <= overflow_q | drop;
      tx_valid_q <= pop;
      if (push) wr_ptr_q <= (wr_ptr_q == 2'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q     <= (rd_ptr_q == 2'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        tx_data_q    <= mem_q[rd_ptr_q][g_record_size-1:0];
        tx_partial_q <= mem_q[rd_ptr_q][g_record_size];
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (push) mem_q[wr_ptr_q] <= {push_partial, push_data};
  end

  assign in_dreq_o    = in_dreq_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_partial_o = tx_partial_q;
  assign overflow_o   = overflow_q;

endmodule
